// File: rtl/dm_obi_slave_arbiter.sv
// Round-robin arbiter sharing the debug module's OBI slave port between NrReq masters.
// Outstanding transactions are tracked in order so each response returns to its issuer.
module dm_obi_slave_arbiter #(
  parameter int NrReq          = 2,
  parameter int BusWidth       = 32,
  parameter int IdWidth        = 1,
  parameter int MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrReq-1:0]                    req_i,
  output logic [NrReq-1:0]                    gnt_o,
  input  logic [NrReq-1:0]                    we_i,
  input  logic [NrReq-1:0][BusWidth-1:0]      addr_i,
  input  logic [NrReq-1:0][BusWidth/8-1:0]    be_i,
  input  logic [NrReq-1:0][BusWidth-1:0]      wdata_i,
  input  logic [NrReq-1:0][IdWidth-1:0]       aid_i,
  output logic [NrReq-1:0]                    rvalid_o,
  output logic [BusWidth-1:0]                 rdata_o,
  output logic [IdWidth-1:0]                  rid_o,
  output logic                                dm_req_o,
  input  logic                                dm_gnt_i,
  output logic                                dm_we_o,
  output logic [BusWidth-1:0]                 dm_addr_o,
  output logic [BusWidth/8-1:0]               dm_be_o,
  output logic [BusWidth-1:0]                 dm_wdata_o,
  output logic [IdWidth-1:0]                  dm_aid_o,
  input  logic                                dm_rvalid_i,
  input  logic [BusWidth-1:0]                 dm_rdata_i
);

  localparam int IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int SlotW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW  = $clog2(MaxOutstanding + 1);

  localparam logic [IdxW-1:0]  LastReq  = IdxW'(NrReq - 1);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0]  MaxCnt   = CntW'(MaxOutstanding);

  logic [IdxW-1:0]    ptr_q;
  logic               lock_q;
  logic [IdxW-1:0]    lidx_q;
  logic [IdxW-1:0]    fifo_idx_q [MaxOutstanding];
  logic [IdWidth-1:0] fifo_aid_q [MaxOutstanding];
  logic [SlotW-1:0]   wr_q, rd_q;
  logic [CntW-1:0]    count_q;

  logic [IdxW-1:0] sel, cand;
  logic            found;
  logic            may_issue, handshake, pop;

  function automatic logic [SlotW-1:0] next_slot(input logic [SlotW-1:0] s);
    return (s == LastSlot) ? '0 : s + 1'b1;
  endfunction

  // A stalled request keeps its master selected so the address phase stays stable.
  always_comb begin
    sel   = ptr_q;
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      sel = lidx_q;
    end else begin
      for (int k = 0; k < NrReq; k++) begin
        cand = IdxW'((int'(ptr_q) + k) % NrReq);
        if (!found && req_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // A same-cycle response frees a slot, so a full FIFO can still accept a new request.
  assign may_issue = (count_q < MaxCnt) | dm_rvalid_i;
  assign dm_req_o  = (|req_i) & may_issue;
  assign handshake = dm_req_o & dm_gnt_i;
  assign pop       = dm_rvalid_i & (count_q != '0);

  always_comb begin
    dm_we_o    = 1'b0;
    dm_addr_o  = '0;
    dm_be_o    = '0;
    dm_wdata_o = '0;
    dm_aid_o   = '0;
    gnt_o      = '0;
    rvalid_o   = '0;
    if (dm_req_o) begin
      dm_we_o    = we_i[sel];
      dm_addr_o  = addr_i[sel];
      dm_be_o    = be_i[sel];
      dm_wdata_o = wdata_i[sel];
      dm_aid_o   = aid_i[sel];
    end
    if (handshake) gnt_o[sel] = 1'b1;
    if (pop) rvalid_o[fifo_idx_q[rd_q]] = 1'b1;
  end

  assign rid_o   = fifo_aid_q[rd_q];
  assign rdata_o = dm_rdata_i;

  // Lock also drops if the locked master withdraws its request, so the arbiter recovers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      lidx_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_idx_q[i] <= '0;
        fifo_aid_q[i] <= '0;
      end
    end else begin
      lock_q <= dm_req_o & ~dm_gnt_i & req_i[sel];
      if (dm_req_o && !dm_gnt_i) lidx_q <= sel;
      if (handshake) begin
        ptr_q            <= (sel == LastReq) ? '0 : sel + 1'b1;
        fifo_idx_q[wr_q] <= sel;
        fifo_aid_q[wr_q] <= aid_i[sel];
        wr_q             <= next_slot(wr_q);
      end
      if (pop) rd_q <= next_slot(rd_q);
      if (handshake && !pop) count_q <= count_q + 1'b1;
      else if (!handshake && pop) count_q <= count_q - 1'b1;
    end
  end

  a_rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dm_rvalid_i |-> (count_q != '0))
    else $warning("dm_obi_slave_arbiter: dm_rvalid_i with no outstanding transaction");

  a_locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_i[lidx_q])
    else $warning("dm_obi_slave_arbiter: locked master dropped req_i before grant");

endmodule

// File: tb/tb_dm_obi_slave_arbiter.sv
// Scoreboard bench for dm_obi_slave_arbiter: expected responses are queued at grant
// time and compared when the downstream slave answers.
module tb_dm_obi_slave_arbiter;

  localparam int NrReq = 2;
  localparam int BusWidth = 32;
  localparam int IdWidth = 1;
  localparam int MaxOutstanding = 2;

  logic                             clk_i = 1'b0;
  logic                             rst_ni;
  logic [NrReq-1:0]                 req_i;
  logic [NrReq-1:0]                 gnt_o;
  logic [NrReq-1:0]                 we_i;
  logic [NrReq-1:0][BusWidth-1:0]   addr_i;
  logic [NrReq-1:0][BusWidth/8-1:0] be_i;
  logic [NrReq-1:0][BusWidth-1:0]   wdata_i;
  logic [NrReq-1:0][IdWidth-1:0]    aid_i;
  logic [NrReq-1:0]                 rvalid_o;
  logic [BusWidth-1:0]              rdata_o;
  logic [IdWidth-1:0]               rid_o;
  logic                             dm_req_o;
  logic                             dm_gnt_i;
  logic                             dm_we_o;
  logic [BusWidth-1:0]              dm_addr_o;
  logic [BusWidth/8-1:0]            dm_be_o;
  logic [BusWidth-1:0]              dm_wdata_o;
  logic [IdWidth-1:0]               dm_aid_o;
  logic                             dm_rvalid_i;
  logic [BusWidth-1:0]              dm_rdata_i;

  typedef struct {
    int                 idx;
    logic [IdWidth-1:0] aid;
  } exp_t;

  exp_t sb[$];
  int   vec_count = 0;
  int   err_count = 0;

  always #5 clk_i = ~clk_i;

  dm_obi_slave_arbiter #(
    .NrReq(NrReq), .BusWidth(BusWidth), .IdWidth(IdWidth), .MaxOutstanding(MaxOutstanding)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .aid_i(aid_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rid_o(rid_o),
    .dm_req_o(dm_req_o), .dm_gnt_i(dm_gnt_i), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_be_o(dm_be_o), .dm_wdata_o(dm_wdata_o), .dm_aid_o(dm_aid_o),
    .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check combinational outputs mid-cycle, then let the edge commit.
  task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv,
                               input logic exp_req, input logic exp_hs, input int exp_sel);
    logic [BusWidth-1:0] data;
    logic [NrReq-1:0]    exp_gnt;
    exp_t                e;
    data        = rv ? BusWidth'($urandom) : '0;
    req_i       = req;
    dm_gnt_i    = gnt;
    dm_rvalid_i = rv;
    dm_rdata_i  = data;
    exp_gnt     = exp_hs ? NrReq'(1 << exp_sel) : '0;
    @(negedge clk_i);
    checkOutput("dm_req", 64'(dm_req_o), 64'(exp_req));
    checkOutput("gnt", 64'(gnt_o), 64'(exp_gnt));
    if (exp_req) begin
      checkOutput("dm_addr", 64'(dm_addr_o), 64'(32'h1000_0000 + 32'(exp_sel) * 32'h100));
      checkOutput("dm_wdata", 64'(dm_wdata_o), 64'(32'hCAFE_0000 + 32'(exp_sel)));
      checkOutput("dm_be", 64'(dm_be_o), 64'(4'(exp_sel + 3)));
      checkOutput("dm_we", 64'(dm_we_o), 64'(exp_sel == 1));
      checkOutput("dm_aid", 64'(dm_aid_o), 64'(aid_i[exp_sel]));
    end else begin
      checkOutput("dm_addr_idle", 64'(dm_addr_o), 64'd0);
    end
    if (rv && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("rvalid", 64'(rvalid_o), 64'(1 << e.idx));
      checkOutput("rid", 64'(rid_o), 64'(e.aid));
      checkOutput("rdata", 64'(rdata_o), 64'(data));
    end else begin
      checkOutput("rvalid_idle", 64'(rvalid_o), 64'd0);
    end
    if (exp_hs) sb.push_back('{idx: exp_sel, aid: aid_i[exp_sel]});
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gnt"}, 64'(gnt_o), 64'd0);
    checkOutput({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
    checkOutput({tag, "_dm_req"}, 64'(dm_req_o), 64'd0);
    checkOutput({tag, "_dm_addr"}, 64'(dm_addr_o), 64'd0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_i       = '0;
    dm_gnt_i    = 1'b0;
    dm_rvalid_i = 1'b0;
    dm_rdata_i  = '0;
    we_i        = 2'b10;
    for (int m = 0; m < NrReq; m++) begin
      addr_i[m]  = 32'h1000_0000 + 32'(m) * 32'h100;
      wdata_i[m] = 32'hCAFE_0000 + 32'(m);
      be_i[m]    = 4'(m + 3);
    end
    aid_i = 2'b10;
    #2;
    checkResetOutputs("reset");
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    $display("[TB] round-robin with zero-latency slave");
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    for (int k = 1; k < 6; k++) applyStimulus(2'b11, 1'b1, 1'b1, 1'b1, 1'b1, k % 2);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] stalled request keeps its master");
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] outstanding limit");
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] response routing with distinct ids");
    aid_i = 2'b01;
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] stray response with empty FIFO");
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] reset with outstanding transaction and lock");
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    req_i       = '0;
    dm_gnt_i    = 1'b0;
    dm_rvalid_i = 1'b0;
    rst_ni      = 1'b0;
    #1;
    checkResetOutputs("midreset");
    sb.delete();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
